// File: rtl/rtl_adder_pkg.sv
// Shared widths, word-vector type and FSM state encoding for the serial 64-bit adder.
package rtl_adder_pkg;

  localparam int OP_W    = 64;
  localparam int WORD_W  = 16;
  localparam int N_WORDS = 4;
  localparam int IDX_W   = $clog2(N_WORDS);

  typedef logic [N_WORDS-1:0][WORD_W-1:0] word_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/rtl_adder_seq_ctrl_if.sv
// Request/result handshake bundle between a requester/consumer (master) and the serial adder (slave).
interface rtl_adder_seq_ctrl_if;
  import rtl_adder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            op_sub;
  logic            res_valid;
  logic            res_ready;
  logic [OP_W-1:0] res_sum;
  logic            res_cout;
  logic            res_ovf;
  logic            busy;

  modport master (
    output req_valid, op_a, op_b, op_sub, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_ovf, busy
  );

  modport slave (
    input  req_valid, op_a, op_b, op_sub, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_ovf, busy
  );

endinterface

// File: rtl/rtl_16bits_adder.sv
// 16-bit ripple-carry adder, purely combinational.
module rtl_16bits_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rtl_adder_seq_ctrl.sv
// Serial 64-bit add/subtract through one 16-bit adder, LS word first; result 4 edges after accept.
// Result held in DONE until res_ready; new requests are only taken in IDLE.
module rtl_adder_seq_ctrl
  import rtl_adder_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  rtl_adder_seq_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  word_vec_t        a_q;
  word_vec_t        b_q;
  word_vec_t        sum_q;
  logic             sub_q;
  logic             carry_q;
  logic             ovf_q;
  logic [IDX_W-1:0] idx_q;

  logic [WORD_W-1:0] add_x;
  logic [WORD_W-1:0] add_y;
  logic [WORD_W-1:0] add_s;
  logic              add_co;
  logic              accept;
  logic              last_word;

  assign accept    = bus.req_valid && (state == IDLE);
  assign last_word = (idx_q == IDX_W'(N_WORDS - 1));

  // Subtract is A + ~B + 1: the +1 comes from the carry register seeded with op_sub.
  assign add_x = a_q[idx_q];
  assign add_y = b_q[idx_q] ^ {WORD_W{sub_q}};

  rtl_16bits_adder u_adder (
    .a    (add_x),
    .b    (add_y),
    .cin  (carry_q),
    .sum  (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.op_a;
      b_q     <= bus.op_b;
      sub_q   <= bus.op_sub;
      carry_q <= bus.op_sub;
      idx_q   <= '0;
    end else if (state == RUN) begin
      sum_q[idx_q] <= add_s;
      carry_q      <= add_co;
      idx_q        <= last_word ? '0 : idx_q + 1'b1;
      if (last_word) begin
        ovf_q <= (add_x[WORD_W-1] == add_y[WORD_W-1]) && (add_s[WORD_W-1] != add_x[WORD_W-1]);
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = carry_q;
  assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_rtl_adder_seq_ctrl.sv
// Directed bench for rtl_adder_seq_ctrl: vector table plus backpressure and mid-run reset sequences.
module tb_rtl_adder_seq_ctrl;
  import rtl_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtl_adder_seq_ctrl_if bus();

  rtl_adder_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        output logic [63:0] sum, output logic cout, output logic ovf,
                        output int lat);
    @(negedge clk);
    check("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.op_sub    = sub;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the operands to prove they were registered at acceptance.
    bus.req_valid = 1'b0;
    bus.op_a      = ~a;
    bus.op_b      = ~b;
    bus.op_sub    = ~sub;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    sum  = bus.res_sum;
    cout = bus.res_cout;
    ovf  = bus.res_ovf;
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("idle_after_handshake", 64'({bus.req_ready, bus.res_valid, bus.busy}), 64'b100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    int          lat;
    int          vcnt;
    int          acc;
    int          unstable;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
    vecs[7] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_res_sum", bus.res_sum, 64'd0);
    check("rst_res_cout", 64'(bus.res_cout), 64'd0);
    check("rst_res_ovf", 64'(bus.res_ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r_sum, r_cout, r_ovf, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("v%0d_sum", i), r_sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), 64'(r_cout), 64'(vecs[i].cout));
      check($sformatf("v%0d_ovf", i), 64'(r_ovf), 64'(vecs[i].ovf));
    end

    // Backpressure: hold req_valid high with a second op queued behind a stalled result.
    @(negedge clk);
    bus.op_a      = 64'h1234_5678_9ABC_DEF0;
    bus.op_b      = 64'h1111_1111_1111_1111;
    bus.op_sub    = 1'b0;
    bus.req_valid = 1'b1;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.op_a   = 64'h7;
    bus.op_b   = 64'h5;
    bus.op_sub = 1'b1;
    vcnt     = 0;
    acc      = 0;
    unstable = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.res_valid) begin
        vcnt++;
        if (bus.res_sum !== 64'h2345_6789_ABCD_F001 || bus.res_cout !== 1'b0 || bus.res_ovf !== 1'b0)
          unstable++;
      end
    end
    check("bp_valid_cycles", 64'(vcnt), 64'd10);
    check("bp_accepts_while_stalled", 64'(acc), 64'd0);
    check("bp_result_unstable_cycles", 64'(unstable), 64'd0);
    bus.res_ready = 1'b1;
    acc = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) bus.res_ready = 1'b0;
      if (bus.req_valid && bus.req_ready) acc++;
    end
    check("bp_accepts_after_handshake", 64'(acc), 64'd1);
    check("bp_op2_valid", 64'(bus.res_valid), 64'd1);
    check("bp_op2_sum", bus.res_sum, 64'h2);
    check("bp_op2_cout", 64'(bus.res_cout), 64'd1);
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("bp_idle", 64'({bus.req_ready, bus.res_valid, bus.busy}), 64'b100);

    // Reset while word 2 is in flight; partial sum is nonzero at that point.
    @(negedge clk);
    bus.op_a      = 64'h0001_0001_0001_0001;
    bus.op_b      = 64'h0001_0001_0001_0001;
    bus.op_sub    = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_run_busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_res_sum", bus.res_sum, 64'd0);
    check("mid_rst_res_cout", 64'(bus.res_cout), 64'd0);
    check("mid_rst_res_ovf", 64'(bus.res_ovf), 64'd0);
    vcnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) vcnt++;
    end
    #1;
    rst = 1'b0;
    check("mid_rst_no_valid_pulse", 64'(vcnt), 64'd0);
    run_op(64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0, r_sum, r_cout, r_ovf, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_sum", r_sum, 64'h0000_0001_0000_0000);
    check("post_rst_cout", 64'(r_cout), 64'd1);
    check("post_rst_ovf", 64'(r_ovf), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtl_adder_seq_ctrl.md
RTL_ADDER_SEQ_CTRL -- requirements
Module: rtl_adder_seq_ctrl

Interface
REQ-001 The block SHALL expose these parameters: none; all widths come from rtl_adder_pkg (OP_W=64, WORD_W=16, N_WORDS=4).
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  block can accept an operation.
REQ-006 op_a  input  64  operand A.
REQ-007 op_b  input  64  operand B.
REQ-008 op_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 res_valid  output  1  result is held and valid.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_sum  output  64  A+B or A-B, modulo 2^64.
REQ-012 res_cout  output  1  carry out of bit 63. For a subtract it is 1 when there is no borrow (A >= B unsigned).
REQ-013 res_ovf  output  1  signed two's-complement overflow.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 The block SHALL compute a 64-bit add/subtract serially through one 16-bit ripple adder, one 16-bit word per cycle, least-significant word first.
REQ-016 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE->RUN on req_valid&&req_ready.
- RUN->DONE after word 3 is captured.
- DONE->IDLE on res_valid&&res_ready.
REQ-017 req_ready SHALL equal (state==IDLE). No new request is accepted in RUN or DONE, including the cycle in which DONE returns to IDLE.
REQ-018 On acceptance the block SHALL register op_a, op_b and op_sub. It SHALL clear the 2-bit word index and load the carry register with op_sub.
REQ-019 In RUN, each cycle the adder inputs SHALL be:
- X = A word[idx].
- Y = B word[idx], bitwise inverted when op_sub=1.
- cin = carry register.
REQ-020 On each RUN edge the block SHALL write the adder sum into res_sum word[idx], load the adder carry-out into the carry register, and increment idx.
REQ-021 The RUN->DONE transition SHALL occur on the edge where idx==3, with no wrap into a 5th word.
REQ-022 res_valid SHALL rise exactly 4 rising edges after the accepting edge and stay high, with res_sum/res_cout/res_ovf stable, until res_ready is sampled high.
REQ-023 res_cout SHALL be the final carry register value.
REQ-024 res_ovf SHALL be set when A[63] == Y[63] and res_sum[63] != A[63], where Y is B after the optional inversion.
REQ-025 Input changes on op_a/op_b/op_sub after acceptance SHALL have no effect on the operation in progress.
REQ-026 Throughput SHALL be one operation per 6 cycles when res_ready is held high: accept, 4 RUN cycles, 1 DONE cycle.
REQ-027 Combinational paths from req_valid or res_ready to any output SHALL NOT exist.

Reset
REQ-028 While rst is high, the block SHALL immediately force state=IDLE, idx=0, carry=0, res_sum=0, res_cout=0, res_ovf=0, res_valid=0 and busy=0, and SHALL drive req_ready=1 once rst is low.
REQ-029 A reset during RUN or DONE SHALL discard the operation without producing a result. The first post-reset edge SHALL be able to accept a new request.

Structure
REQ-030 rtl_adder_pkg SHALL hold OP_W, WORD_W, N_WORDS and the state enum type (IDLE, RUN, DONE).
REQ-031 The block SHALL instantiate exactly one existing rtl_16bits_adder as its datapath sub-module and SHALL NOT use a wider "+" operator.

Verification
REQ-032 Add, A=64'h0000_0000_0000_FFFF, B=64'h1 -> res_sum=64'h1_0000, cout=0, ovf=0. res_valid appears 4 edges after acceptance.
REQ-033 Carry chain, A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1 -> sum=0, cout=1, ovf=0.
REQ-034 Signed overflow, A=64'h7FFF_FFFF_FFFF_FFFF, B=1, add -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
REQ-035 Subtract with borrow, A=5, B=7, op_sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then A=7, B=5 -> sum=2, cout=1.
REQ-036 Backpressure, with res_ready=0 for 10 cycles and req_valid held high -> the result stays stable, req_ready=0 throughout, and exactly one new acceptance occurs after the res_ready handshake.
REQ-037 Reset asserted during RUN word 2 -> all outputs return to their reset values immediately, no res_valid pulse occurs, and the next request completes correctly.
